// File: rtl/shift_reg_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | shift_reg_controller                                                       |
// | Moore sequencer that loads a 4-bit bidirectional shift register, issues N  |
// | shifts while streaming the outgoing bits, then pulses done.                |
// | Optional feature macro: ROTATE_EN (outgoing bit recirculated when rot=1).  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module shift_reg_controller #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             dir,
   input  logic [CNT_W-1:0] count,
   input  logic [WIDTH-1:0] data_in,
   input  logic             fill,
   input  logic             rot,
   input  logic             abort,
   input  logic [WIDTH-1:0] reg_q,
   output logic [1:0]       S,
   output logic [1:0]       shift_in,
   output logic [WIDTH-1:0] load_data,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [1:0]       c_mode_hold  = 2'b00;
   localparam logic [1:0]       c_mode_right = 2'b01;
   localparam logic [1:0]       c_mode_left  = 2'b10;
   localparam logic [1:0]       c_mode_load  = 2'b11;
   localparam logic [CNT_W-1:0] c_full_cnt   = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);

   state_t           r_state;
   logic [1:0]       r_s;
   logic [WIDTH-1:0] r_load_data;
   logic             r_dir;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] r_remaining;
   logic             r_ser_valid;
   logic             r_busy;
   logic             r_done;
   logic [CNT_W-1:0] w_count_clamped;
   logic             w_out_bit;
   logic             w_shift_bit;
   logic             w_unused;

   // Zero and anything beyond the register width both mean a full-width job.
   assign w_count_clamped = ((count == '0) || (count > c_full_cnt)) ? c_full_cnt : count;
   assign w_out_bit       = r_dir ? reg_q[WIDTH-1] : reg_q[0];

`ifdef ROTATE_EN
   logic r_rot;
   assign w_shift_bit = r_rot ? w_out_bit : fill;
   assign w_unused    = ^reg_q;
`else
   assign w_shift_bit = fill;
   assign w_unused    = ^{reg_q, rot};
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_s         <= c_mode_hold;
         r_load_data <= '0;
         r_dir       <= 1'b0;
         r_count     <= '0;
         r_remaining <= '0;
         r_ser_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
`ifdef ROTATE_EN
         r_rot       <= 1'b0;
`endif
      end else if (abort && (r_state != ST_IDLE)) begin
         r_state     <= ST_IDLE;
         r_s         <= c_mode_hold;
         r_ser_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state     <= ST_LOAD;
                  r_load_data <= data_in;
                  r_dir       <= dir;
                  r_count     <= w_count_clamped;
`ifdef ROTATE_EN
                  r_rot       <= rot;
`endif
                  r_s         <= c_mode_load;
                  r_busy      <= 1'b1;
               end
            end
            ST_LOAD: begin
               r_state     <= ST_SHIFT;
               r_remaining <= r_count;
               r_s         <= r_dir ? c_mode_left : c_mode_right;
               r_ser_valid <= 1'b1;
            end
            ST_SHIFT: begin
               r_remaining <= r_remaining - c_one;
               if (r_remaining == c_one) begin
                  r_state     <= ST_DONE;
                  r_s         <= c_mode_hold;
                  r_ser_valid <= 1'b0;
                  r_done      <= 1'b1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Serial bit and shift-in follow the live register contents while shifting.
   assign S         = r_s;
   assign load_data = r_load_data;
   assign ser_valid = r_ser_valid;
   assign busy      = r_busy;
   assign done      = r_done;
   assign ser_out   = r_ser_valid & w_out_bit;
   assign shift_in  = r_ser_valid ? {2{w_shift_bit}} : 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_shift_reg_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_shift_reg_controller                                                    |
// | Self-checking bench: shift register model, vector table, random jobs.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_shift_reg_controller;

   localparam int WIDTH = 4;
   localparam int CNT_W = 3;
`ifdef ROTATE_EN
   localparam bit ROT_ON = 1'b1;
`else
   localparam bit ROT_ON = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n, start, dir, fill, rot, abort;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] reg_q = '0;
   logic [1:0]       S, shift_in;
   logic [WIDTH-1:0] load_data;
   logic             ser_out, ser_valid, busy, done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   shift_reg_controller #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .count(count),
      .data_in(data_in), .fill(fill), .rot(rot), .abort(abort), .reg_q(reg_q),
      .S(S), .shift_in(shift_in), .load_data(load_data), .ser_out(ser_out),
      .ser_valid(ser_valid), .busy(busy), .done(done)
   );

   // The 4-bit bidirectional shift register the controller drives.
   always @(posedge clk) begin
      case (S)
         2'b01:   reg_q <= {shift_in[1], reg_q[3:1]};
         2'b10:   reg_q <= {reg_q[2:0], shift_in[0]};
         2'b11:   reg_q <= load_data;
         default: reg_q <= reg_q;
      endcase
   end

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Reference: job outcome from word arithmetic; limit<0 means run to completion.
   function automatic void model_job(input logic [3:0] d, input bit dr, input logic [2:0] c,
                                     input bit f, input bit r, input int limit,
                                     output int n, output logic [3:0] ser,
                                     output logic [3:0] fin, output logic [3:0] ins);
      int q, o, i;
      q   = int'(d);
      n   = (c == 0 || c > 4) ? 4 : int'(c);
      if (limit >= 0 && limit < n) n = limit;
      ser = '0;
      ins = '0;
      for (int k = 0; k < n; k++) begin
         o      = dr ? (q >> 3) & 1 : q & 1;
         i      = (ROT_ON && r) ? o : int'(f);
         ser[k] = o[0];
         ins[k] = i[0];
         q      = dr ? ((q << 1) | i) & 15 : (q >> 1) | (i << 3);
      end
      fin = q[3:0];
   endfunction

   task automatic run_job(input string tag, input logic [3:0] d, input bit dr,
                          input logic [2:0] c, input bit f, input bit r,
                          input int n_exp, input logic [3:0] ser_exp, input logic [3:0] fin_exp,
                          input int abort_at, input int poke_at);
      int n_m, nload, nser, ndone, nbusy, didx, bad;
      bit idle;
      logic [3:0] ser_m, fin_m, ins_m, got;
      model_job(d, dr, c, f, r, abort_at, n_m, ser_m, fin_m, ins_m);
      data_in = d; dir = dr; count = c; fill = f; rot = r; start = 1'b1;
      @(negedge clk);
      start = 1'b0; data_in = ~d; dir = ~dr; count = 3'd1; rot = ~r;
      nload = 0; nser = 0; ndone = 0; nbusy = 0; didx = -1; bad = 0; idle = 1'b0; got = '0;
      for (int i = 0; i < 40; i++) begin
         if (!busy) begin
            idle = 1'b1;
            break;
         end
         if (S == 2'b11) nload++;
         if (ser_valid) begin
            if (nser < 4) begin
               got[nser] = ser_out;
               if (shift_in !== {2{ins_m[nser]}}) bad++;
            end
            if (S !== (dr ? 2'b10 : 2'b01)) bad++;
            nser++;
         end
         if (done) begin
            ndone++;
            didx = i;
            if (S !== 2'b00) bad++;
         end
         nbusy++;
         abort = (i == abort_at);
         start = (i == poke_at);
         if (start) begin
            data_in = ~d; dir = ~dr; count = 3'd1;
         end
         @(negedge clk);
      end
      abort = 1'b0; start = 1'b0;
      chk({tag, "_timeout"}, int'(idle), 1);
      chk({tag, "_loads"}, nload, 1);
      chk({tag, "_shifts"}, nser, n_exp);
      chk({tag, "_ser"}, int'(got), int'(ser_exp));
      chk({tag, "_reg_q"}, int'(reg_q), int'(fin_exp));
      chk({tag, "_mode"}, bad, 0);
      chk({tag, "_busy_cycles"}, nbusy, (abort_at >= 0) ? n_exp + 1 : n_exp + 2);
      chk({tag, "_done_pulses"}, ndone, (abort_at >= 0) ? 0 : 1);
      if (abort_at < 0) chk({tag, "_done_cycle"}, didx, n_exp + 1);
   endtask

   typedef struct {
      logic [3:0] d;
      bit         dr;
      logic [2:0] c;
      bit         f;
      bit         r;
      int         n;
      logic [3:0] ser;
      logic [3:0] fin;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int n_m, gap, poke;
      logic [3:0] ser_m, fin_m, ins_m, rd;
      logic [2:0] rc;
      bit rdr, rf, rr;

      vecs[0] = '{4'b1011, 1'b0, 3'd4, 1'b0, 1'b0, 4, 4'b1011, 4'b0000};
      vecs[1] = '{4'b1011, 1'b1, 3'd2, 1'b1, 1'b0, 2, 4'b0001, 4'b1111};
      vecs[2] = '{4'b1011, 1'b0, 3'd0, 1'b0, 1'b0, 4, 4'b1011, 4'b0000};
      vecs[3] = '{4'b1011, 1'b0, 3'd7, 1'b0, 1'b0, 4, 4'b1011, 4'b0000};
      vecs[4] = '{4'b1001, 1'b1, 3'd4, 1'b0, 1'b1, 4, 4'b1001, ROT_ON ? 4'b1001 : 4'b0000};
      vecs[5] = '{4'b0110, 1'b0, 3'd1, 1'b1, 1'b0, 1, 4'b0000, 4'b1011};

      rst_n = 1'b0; start = 1'b0; dir = 1'b0; count = '0; data_in = '0;
      fill = 1'b0; rot = 1'b0; abort = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_S", int'(S), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_ser_valid", int'(ser_valid), 0);
      chk("rst_shift_in", int'(shift_in), 0);
      chk("rst_load_data", int'(load_data), 0);
      rst_n = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("idle_abort_ignored", int'(busy), 0);

      for (int i = 0; i < 6; i++)
         run_job($sformatf("vec%0d", i), vecs[i].d, vecs[i].dr, vecs[i].c, vecs[i].f,
                 vecs[i].r, vecs[i].n, vecs[i].ser, vecs[i].fin, -1, -1);

      run_job("abort", 4'b1011, 1'b0, 3'd4, 1'b0, 1'b0, 2, 4'b0011, 4'b0010, 2, -1);
      chk("abort_stays_idle", int'(busy), 0);
      run_job("poke_shift", 4'b1011, 1'b0, 3'd4, 1'b0, 1'b0, 4, 4'b1011, 4'b0000, -1, 1);
      run_job("poke_done", 4'b1011, 1'b1, 3'd2, 1'b1, 1'b0, 2, 4'b0001, 4'b1111, -1, 3);
      @(negedge clk);
      chk("poke_done_no_restart", int'(busy), 0);

      for (int j = 0; j < 24; j++) begin
         rd = 4'($urandom); rdr = 1'($urandom); rc = 3'($urandom_range(0, 7));
         rf = 1'($urandom); rr = 1'($urandom);
         poke = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : -1;
         model_job(rd, rdr, rc, rf, rr, -1, n_m, ser_m, fin_m, ins_m);
         run_job($sformatf("rnd%0d", j), rd, rdr, rc, rf, rr, n_m, ser_m, fin_m, -1, poke);
         gap = $urandom_range(0, 2);
         repeat (gap) @(negedge clk);
      end

      data_in = 4'b1011; dir = 1'b0; count = 3'd4; fill = 1'b0; rot = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("pre_reset_in_shift", int'(ser_valid), 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_S", int'(S), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      chk("midrst_ser_valid", int'(ser_valid), 0);
      chk("midrst_ser_out", int'(ser_out), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", int'(busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
